// File: rtl/serial_subtractor_nbit_if.sv
// Handshake/operand bundle for the bit-serial subtractor.
//   start      request pulse from the master
//   a, b       minuend and subtrahend, sampled when a request is accepted
//   borrow_in  incoming borrow, subtracted at bit 0
//   busy       subtraction in progress
//   done       one-cycle strobe, diff/underflow valid
//   diff       registered result, (a - b - borrow_in) mod 2^BIT_WIDTH
//   underflow  final borrow out
interface serial_subtractor_nbit_if #(
  parameter int BIT_WIDTH = 4
);
  logic                 start;
  logic [BIT_WIDTH-1:0] a;
  logic [BIT_WIDTH-1:0] b;
  logic                 borrow_in;
  logic                 busy;
  logic                 done;
  logic [BIT_WIDTH-1:0] diff;
  logic                 underflow;

  modport master (
    output start, a, b, borrow_in,
    input  busy, done, diff, underflow
  );

  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, diff, underflow
  );
endinterface

// File: rtl/serial_subtractor_nbit.sv
// Bit-serial n-bit subtractor: diff = a - b - borrow_in, one bit per clock,
// LSB first, through a single full-subtractor cell and a registered borrow.
// Ports:
//   clk    system clock, rising edge
//   n_rst  asynchronous active-low reset
//   bus    slave side of serial_subtractor_nbit_if (start/operands in,
//          busy/done/diff/underflow out, all outputs registered)
//
// state  | meaning
// IDLE   | waiting for start; operands sampled on the accepting edge
// SHIFT  | one result bit per edge, busy=1
// DONE   | done=1 for one cycle; start here is accepted back-to-back
module serial_subtractor_nbit #(
  parameter int BIT_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  serial_subtractor_nbit_if.slave bus
);
  localparam int CNT_W = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [BIT_WIDTH-1:0] a_sh_q, a_sh_d;
  logic [BIT_WIDTH-1:0] b_sh_q, b_sh_d;
  logic [BIT_WIDTH-1:0] res_q, res_d;
  logic                 brw_q, brw_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_WIDTH-1:0] diff_q, diff_d;
  logic                 underflow_q, underflow_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic d_bit;
  logic brw_nxt;

  always_comb begin
    d_bit   = a_sh_q[0] ^ b_sh_q[0] ^ brw_q;
    brw_nxt = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & brw_q);

    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_d       = res_q;
    brw_d       = brw_q;
    cnt_d       = cnt_q;
    diff_d      = diff_q;
    underflow_d = underflow_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          brw_d   = bus.borrow_in;
          res_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = {d_bit, res_q[BIT_WIDTH-1:1]};
        brw_d  = brw_nxt;
        // cnt_q names the bit being processed on this edge; the counter
        // holds at its last value instead of wrapping.
        if (cnt_q == CNT_LAST) begin
          state_d     = S_DONE;
          diff_d      = res_d;
          underflow_d = brw_nxt;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status flags are registered copies of the next state so outputs
    // come straight from flops.
    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_q       <= '0;
      brw_q       <= 1'b0;
      cnt_q       <= '0;
      diff_q      <= '0;
      underflow_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_q       <= res_d;
      brw_q       <= brw_d;
      cnt_q       <= cnt_d;
      diff_q      <= diff_d;
      underflow_q <= underflow_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.diff      = diff_q;
  assign bus.underflow = underflow_q;
endmodule
